controle_semaforo: RTL and testbench
====================================

Name: controle_semaforo

Overview:
- Phase sequencer for one traffic-light approach, driving the 4-bit down-counter stage directly downstream.
- Selects the per-phase preset value and issues the one-cycle load pulse (botao).
- Watches the counter output for 0000 and advances GREEN -> YELLOW -> RED.
- Handles a pedestrian request and a counter-stall watchdog.

Parameters:
- T_VERDE, 9, green preset loaded into the counter (1..15).
- T_AMARELO, 3, yellow preset (1..15).
- T_VERMELHO, 7, red preset (1..15).
- T_VERDE_MIN, 4, minimum elapsed green counts before a pedestrian request may cut green short (0..T_VERDE).
- WD_MAX, 31, watchdog limit in clocks per phase (must exceed 17).

Ports:
- clock  in  1  system clock; the counter stage uses the same clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run request; sampled as described below.
- ped_req  in  1  asynchronous pedestrian button, level.
- cnt_q  in  4  current value Q of the down-counter.
- preset  out  4  preset value presented to the counter.
- botao  out  1  counter load pulse, exactly 1 clock wide.
- luz_verde, luz_amarela, luz_vermelha  out  1 each  lamp drives.
- ped_walk  out  1  pedestrian walk lamp.
- fase  out  2  encoded state: 0 = IDLE/RED, 1 = GREEN, 2 = YELLOW, 3 = FAULT.
- erro  out  1  watchdog fault flag, sticky until reset.

Behaviour:
- Reset values:
  - state = IDLE, preset = 0000, botao = 0.
  - luz_vermelha = 1; all other lamps = 0; ped_walk = 0; erro = 0.
  - Synchroniser, ped_pend and watchdog are all cleared.
- All outputs are registered. Lamps are decoded from the state register only.
- States: IDLE, VERDE, AMARELO, VERMELHO, FALHA.
- Counter contract:
  - The counter captures preset on the rising edge at which botao = 1.
  - cnt_q shows the new value from the next cycle and decrements by 1 per clock.
- Zero detect:
  - Zero is valid only when cnt_q = 0000 and botao = 0.
  - The cycle with botao = 1 is a guard cycle; stale zeros are ignored.
- Transitions. Each entry into a timed state drives botao = 1 and preset = that state's T for one clock, on the same edge the state changes.
  - IDLE & enable = 1 -> VERDE, load T_VERDE.
  - VERDE & zero -> AMARELO, load T_AMARELO.
  - VERDE & ped_pend & (T_VERDE - cnt_q) >= T_VERDE_MIN & botao = 0 -> AMARELO, load T_AMARELO (early cut).
  - AMARELO & zero -> VERMELHO, load T_VERMELHO. ped_pend is cleared on this edge.
  - VERMELHO & zero & enable = 1 -> VERDE, load T_VERDE.
  - VERMELHO & zero & enable = 0 -> IDLE, no load (botao stays 0).
  - Any timed state & watchdog = WD_MAX -> FALHA, erro = 1.
  - FALHA is left only by reset.
- Phase length: a preset of N gives N+2 clocks in that state (1 load cycle + N+1 counting cycles).
- Lamps:
  - VERDE: verde only. AMARELO: amarela only. VERMELHO and IDLE: vermelha only.
  - FALHA: amarela toggles every clock; verde and vermelha are off.
  - ped_walk = 1 only in VERMELHO.
- Pedestrian:
  - ped_req passes through a 2-FF synchroniser.
  - A rising edge of the synchronised signal sets ped_pend, in any state except FALHA.
  - A request arriving during VERMELHO is held for the next cycle.
- Watchdog:
  - 5-bit counter, cleared on every state change, increments otherwise in timed states.
  - Saturates at WD_MAX.
- Simultaneous events:
  - Zero and an early-cut condition in the same cycle in VERDE -> single transition to AMARELO, single load.
  - Watchdog limit wins over all other transitions.
- enable is ignored except in IDLE and at the VERMELHO zero.
- Reset asserted mid-phase clears everything immediately. A botao pulse in flight is aborted (botao = 0 asynchronously).

Decomposition:
- Shared package (semaforo_pkg):
  - state encoding constants (IDLE, VERDE, AMARELO, VERMELHO, FALHA);
  - fase encodings;
  - 4-bit count width constant.
- Sub-module sinc_borda: 2-FF synchroniser plus rising-edge detector for ped_req.
- Everything else stays in one module.

Test Plan:
- Defaults, bench counter model:
  - reset, then enable = 1 -> botao high 1 clock with preset = 1001.
  - Green lasts 11 clocks, yellow 5, red 9.
  - Loads of 0011 and 0111 appear at the phase edges; the cycle repeats.
- Guard cycle: hold cnt_q = 0000 during the VERDE load cycle -> no transition; botao pulses exactly once.
- Pedestrian early cut:
  - ped_req pulse 3 clocks after green load -> still green while elapsed < 4.
  - AMARELO entered the cycle cnt_q = 5.
  - ped_walk = 1 throughout the following VERMELHO; ped_pend is cleared.
- enable dropped mid-green -> full cycle finishes; at red zero, state goes to IDLE with no botao; vermelha = 1.
- Counter stall: cnt_q frozen at 0110 in AMARELO -> after 31 clocks, FALHA with erro = 1 and amarela toggling; only reset recovers.
- Async reset asserted in the same cycle as botao -> botao and all lamps return to reset values before the next edge.

Source files
------------

// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared state, phase encodings and widths for the traffic-light sequencer
package semaforo_pkg;

  localparam int CNT_W = 4;
  localparam int WD_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERDE,
    ST_AMARELO,
    ST_VERMELHO,
    ST_FALHA
  } estado_t;

  localparam logic [1:0] FASE_VERMELHO = 2'd0;
  localparam logic [1:0] FASE_VERDE    = 2'd1;
  localparam logic [1:0] FASE_AMARELO  = 2'd2;
  localparam logic [1:0] FASE_FALHA    = 2'd3;

  function automatic logic [1:0] fase_de(estado_t e);
    case (e)
      ST_VERDE:   return FASE_VERDE;
      ST_AMARELO: return FASE_AMARELO;
      ST_FALHA:   return FASE_FALHA;
      default:    return FASE_VERMELHO;
    endcase
  endfunction

endpackage

// File: rtl/sinc_borda.sv
// rtl/sinc_borda.sv - 2-FF synchroniser with rising-edge detect for the pedestrian button
module sinc_borda (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/controle_semaforo.sv
// rtl/controle_semaforo.sv - phase sequencer driving the preset/load of a 4-bit down-counter
module controle_semaforo
  import semaforo_pkg::*;
#(
  parameter int T_VERDE     = 9,
  parameter int T_AMARELO   = 3,
  parameter int T_VERMELHO  = 7,
  parameter int T_VERDE_MIN = 4,
  parameter int WD_MAX      = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             ped_req,
  input  logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] preset,
  output logic             botao,
  output logic             luz_verde,
  output logic             luz_amarela,
  output logic             luz_vermelha,
  output logic             ped_walk,
  output logic [1:0]       fase,
  output logic             erro
);

  estado_t          estado, estado_n;
  logic [WD_W-1:0]  wd;
  logic             ped_pend;
  logic             ped_rise;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero, corte, timed, clr_ped;

  sinc_borda u_sinc (
    .clock    (clock),
    .reset    (reset),
    .async_in (ped_req),
    .rise     (ped_rise)
  );

  // botao high marks the load cycle; cnt_q is stale there and must not count as zero
  always_comb begin
    estado_n = estado;
    load     = 1'b0;
    load_val = preset;
    zero     = (cnt_q == '0) && !botao;
    corte    = ped_pend && !botao && ((int'(cnt_q) + T_VERDE_MIN) <= T_VERDE);
    timed    = (estado == ST_VERDE) || (estado == ST_AMARELO) || (estado == ST_VERMELHO);
    if (timed && (wd == WD_W'(WD_MAX))) begin
      estado_n = ST_FALHA;
    end else begin
      case (estado)
        ST_IDLE: if (enable) begin
          estado_n = ST_VERDE;
          load     = 1'b1;
          load_val = CNT_W'(T_VERDE);
        end
        ST_VERDE: if (zero || corte) begin
          estado_n = ST_AMARELO;
          load     = 1'b1;
          load_val = CNT_W'(T_AMARELO);
        end
        ST_AMARELO: if (zero) begin
          estado_n = ST_VERMELHO;
          load     = 1'b1;
          load_val = CNT_W'(T_VERMELHO);
        end
        ST_VERMELHO: if (zero) begin
          if (enable) begin
            estado_n = ST_VERDE;
            load     = 1'b1;
            load_val = CNT_W'(T_VERDE);
          end else begin
            estado_n = ST_IDLE;
          end
        end
        default: estado_n = ST_FALHA;
      endcase
    end
    clr_ped = (estado == ST_AMARELO) && (estado_n == ST_VERMELHO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= ST_IDLE;
      wd           <= '0;
      ped_pend     <= 1'b0;
      preset       <= '0;
      botao        <= 1'b0;
      luz_verde    <= 1'b0;
      luz_amarela  <= 1'b0;
      luz_vermelha <= 1'b1;
      ped_walk     <= 1'b0;
      fase         <= FASE_VERMELHO;
      erro         <= 1'b0;
    end else begin
      estado <= estado_n;
      botao  <= load;
      if (load) preset <= load_val;

      if (estado_n != estado) wd <= '0;
      else if (timed && (wd != WD_W'(WD_MAX))) wd <= wd + 1'b1;

      if (ped_rise && (estado != ST_FALHA)) ped_pend <= 1'b1;
      else if (clr_ped) ped_pend <= 1'b0;

      // lamps follow the next state so they line up with the state register
      luz_verde    <= (estado_n == ST_VERDE);
      luz_amarela  <= (estado_n == ST_AMARELO) ||
                      ((estado_n == ST_FALHA) && ((estado != ST_FALHA) || !luz_amarela));
      luz_vermelha <= (estado_n == ST_IDLE) || (estado_n == ST_VERMELHO);
      ped_walk     <= (estado_n == ST_VERMELHO);
      fase         <= fase_de(estado_n);
      erro         <= erro | (estado_n == ST_FALHA);
    end
  end

endmodule

// File: tb/tb_controle_semaforo.sv
// tb/tb_controle_semaforo.sv - randomized and directed bench with a phase-level reference model
module tb_controle_semaforo;

  localparam int TV = 9, TA = 3, TR = 7, TMIN = 4, WDM = 31;
  localparam int P_IDLE = 0, P_VERDE = 1, P_AMAR = 2, P_VERM = 3, P_FALHA = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       ped_req = 1'b0;
  logic [3:0] cnt_q;
  logic [3:0] preset;
  logic       botao, luz_verde, luz_amarela, luz_vermelha, ped_walk, erro;
  logic [1:0] fase;
  logic       freeze = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  controle_semaforo #(
    .T_VERDE(TV), .T_AMARELO(TA), .T_VERMELHO(TR), .T_VERDE_MIN(TMIN), .WD_MAX(WDM)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req), .cnt_q(cnt_q),
    .preset(preset), .botao(botao), .luz_verde(luz_verde), .luz_amarela(luz_amarela),
    .luz_vermelha(luz_vermelha), .ped_walk(ped_walk), .fase(fase), .erro(erro)
  );

  always #5 clock = ~clock;

  // model: current phase, clocks spent in it, whether it began with a load, pending request
  typedef struct packed {
    logic [2:0]  ph;
    logic [15:0] t;
    logic        ld;
    logic        pend;
    logic [3:0]  pre;
    logic [2:0]  sq;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t m_step(mstate_t s, logic en, logic pr, logic [3:0] c);
    mstate_t n;
    int  nph;
    bit  ld, zero, rise;
    int  lv;
    n    = s;
    nph  = int'(s.ph);
    ld   = 1'b0;
    lv   = int'(s.pre);
    zero = (c == 4'd0) && !s.ld;
    rise = s.sq[1] && !s.sq[2];
    if ((nph == P_VERDE || nph == P_AMAR || nph == P_VERM) && s.t >= 16'(WDM)) nph = P_FALHA;
    else if (nph == P_IDLE && en) begin nph = P_VERDE; ld = 1'b1; lv = TV; end
    else if (nph == P_VERDE && (zero || (s.pend && !s.ld && int'(c) <= TV - TMIN))) begin
      nph = P_AMAR; ld = 1'b1; lv = TA;
    end
    else if (nph == P_AMAR && zero) begin nph = P_VERM; ld = 1'b1; lv = TR; end
    else if (nph == P_VERM && zero) begin
      if (en) begin nph = P_VERDE; ld = 1'b1; lv = TV; end
      else nph = P_IDLE;
    end
    if (rise && s.ph != 3'(P_FALHA)) n.pend = 1'b1;
    else if (s.ph == 3'(P_AMAR) && nph == P_VERM) n.pend = 1'b0;
    n.sq  = {s.sq[1:0], pr};
    n.t   = (nph != int'(s.ph)) ? 16'd0 : s.t + 16'd1;
    n.ld  = ld;
    n.pre = 4'(lv);
    n.ph  = 3'(nph);
    return n;
  endfunction

  function automatic logic [11:0] m_out(mstate_t s);
    logic v, a, r, w, e;
    logic [1:0] f;
    v = (s.ph == 3'(P_VERDE));
    a = (s.ph == 3'(P_AMAR)) || (s.ph == 3'(P_FALHA) && !s.t[0]);
    r = (s.ph == 3'(P_IDLE)) || (s.ph == 3'(P_VERM));
    w = (s.ph == 3'(P_VERM));
    e = (s.ph == 3'(P_FALHA));
    f = v ? 2'd1 : (s.ph == 3'(P_AMAR)) ? 2'd2 : e ? 2'd3 : 2'd0;
    return {s.pre, s.ld, v, a, r, w, f, e};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) ms <= '0;
    else ms <= m_step(ms, enable, ped_req, cnt_q);
  end

  // downstream counter, fed by the model's expected load so stimulus never depends on the DUT
  always @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else if (freeze) cnt_q <= 4'd6;
    else if (ms.ld) cnt_q <= ms.pre;
    else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  always @(negedge clock) begin
    logic [11:0] act, exp_v;
    act   = {preset, botao, luz_verde, luz_amarela, luz_vermelha, ped_walk, fase, erro};
    exp_v = m_out(ms);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL outputs t=%0t actual=%03h required=%03h", $time, act, exp_v);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_load(input logic [1:0] f);
    int k;
    k = 0;
    while (!(botao && fase == f) && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("wait_load", int'(k < 200), 1);
  endtask

  task automatic measure(input logic [1:0] f, output int len, output int nb, output int nw);
    len = 0; nb = 0; nw = 0;
    while (fase == f && len < 100) begin
      nb += int'(botao);
      nw += int'(ped_walk);
      len++;
      @(negedge clock);
    end
  endtask

  initial begin
    int len, nb, nw, a0;
    repeat (3) @(negedge clock);
    check("rst_botao", int'(botao), 0);
    check("rst_preset", int'(preset), 0);
    check("rst_vermelha", int'(luz_vermelha), 1);
    check("rst_erro", int'(erro), 0);
    reset = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    check("first_load_botao", int'(botao), 1);
    check("first_load_preset", int'(preset), 9);
    measure(2'd1, len, nb, nw);
    check("green_len", len, 11);
    check("green_botao_count", nb, 1);
    check("yellow_preset", int'(preset), 3);
    measure(2'd2, len, nb, nw);
    check("yellow_len", len, 5);
    check("red_preset", int'(preset), 7);
    measure(2'd3 - 2'd3, len, nb, nw);
    check("red_len", len, 9);
    check("green_again", int'(fase), 1);

    // pedestrian early cut
    wait_load(2'd1);
    len = 0;
    while (fase == 2'd1 && len < 100) begin
      if (len == 3) ped_req = 1'b1;
      if (len == 5) ped_req = 1'b0;
      len++;
      @(negedge clock);
    end
    check("ped_green_short", int'(len < 11 && len >= TMIN + 2), 1);
    measure(2'd2, len, nb, nw);
    measure(2'd0, len, nb, nw);
    check("ped_walk_red", nw, 9);
    measure(2'd1, len, nb, nw);
    check("pend_cleared_green_len", len, 11);

    // enable dropped mid-green
    wait_load(2'd1);
    repeat (3) @(negedge clock);
    enable = 1'b0;
    measure(2'd1, len, nb, nw);
    measure(2'd2, len, nb, nw);
    check("drop_yellow_len", len, 5);
    measure(2'd0, len, nb, nw);
    check("drop_idle_vermelha", int'(luz_vermelha), 1);
    nb = 0;
    repeat (5) begin
      nb += int'(botao) + int'(fase != 2'd0);
      @(negedge clock);
    end
    check("idle_quiet", nb, 0);

    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 12) == 0) ped_req = ~ped_req;
      @(negedge clock);
    end

    // counter stall in yellow
    enable = 1'b1;
    ped_req = 1'b0;
    wait_load(2'd2);
    freeze = 1'b1;
    measure(2'd2, len, nb, nw);
    check("stall_yellow_len", len, WDM + 1);
    check("stall_fase", int'(fase), 3);
    check("stall_erro", int'(erro), 1);
    a0 = int'(luz_amarela);
    @(negedge clock);
    check("amarela_toggle", int'(luz_amarela), 1 - a0);
    for (int i = 0; i < 10; i++) begin
      enable = $urandom_range(0, 1);
      ped_req = $urandom_range(0, 1);
      @(negedge clock);
    end
    check("falha_sticky", int'(fase), 3);

    // async reset while a load pulse is out
    freeze = 1'b0;
    ped_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;
    @(posedge clock);
    #2;
    check("pre_abort_botao", int'(botao), 1);
    reset = 1'b1;
    #1;
    check("abort_botao", int'(botao), 0);
    check("abort_verde", int'(luz_verde), 0);
    check("abort_vermelha", int'(luz_vermelha), 1);
    check("abort_erro", int'(erro), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
